// File: rtl/if_fetch_pkg.sv
// Shared bus widths, zero constant and fetch FSM encodings for the instruction fetch stage.
package if_fetch_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    localparam logic [InstBus-1:0] ZeroWorld = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_e;

    function automatic logic [InstAddrBus-1:0] word_align(input logic [InstAddrBus-1:0] addr);
        return {addr[InstAddrBus-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_icache.sv
// Direct-mapped instruction cache: combinational lookup, synchronous fill and valid-bit clear.
// Only instantiated by if_fetch when ICACHE_EN is defined.
module if_fetch_icache
    import if_fetch_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [InstAddrBus-1:0] lookup_addr,
    output logic                   lookup_hit,
    output logic [InstBus-1:0]     lookup_data,
    input  logic                   fill_en,
    input  logic [InstAddrBus-1:0] fill_addr,
    input  logic [InstBus-1:0]     fill_data
);

    localparam int IdxW = $clog2(DEPTH);
    localparam int TagW = InstAddrBus - IdxW - 2;

    logic [DEPTH-1:0] r_valid;
    logic [TagW-1:0]  r_tag  [DEPTH];
    logic [InstBus-1:0] r_data [DEPTH];

    logic [IdxW-1:0] w_lk_idx;
    logic [TagW-1:0] w_lk_tag;
    logic [IdxW-1:0] w_fl_idx;

    assign w_lk_idx = lookup_addr[IdxW+1:2];
    assign w_lk_tag = lookup_addr[InstAddrBus-1:IdxW+2];
    assign w_fl_idx = fill_addr[IdxW+1:2];

    assign lookup_hit  = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign lookup_data = r_data[w_lk_idx];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_valid <= '0;
        end else if (fill_en) begin
            r_valid[w_fl_idx] <= 1'b1;
        end
    end

    // Tag and data storage carry no reset; valid bits alone gate their use.
    always_ff @(posedge clk_in) begin
        if (fill_en) begin
            r_tag[w_fl_idx]  <= fill_addr[InstAddrBus-1:IdxW+2];
            r_data[w_fl_idx] <= fill_data;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: assembles a 32-bit instruction from four little-endian memory bytes.
// Define ICACHE_EN to compile in a direct-mapped instruction cache of ICACHE_DEPTH lines.
//
// state    | meaning
// ST_IDLE  | latch pc_in; start a memory fetch, or issue directly on a cache hit
// ST_FETCH | mem_req high, collecting bytes 0..3 of the instruction
// ST_HOLD  | inst_valid_out high, waiting for ID to accept (stall_in[1] low)
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int ICACHE_DEPTH = 16
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    input  logic [InstAddrBus-1:0] pc_in,
    input  logic                   branch_or_not,
    input  logic [5:0]             stall_in,
    input  logic                   mem_byte_valid,
    input  logic [7:0]             mem_byte_data,
    output logic                   mem_req,
    output logic [InstAddrBus-1:0] mem_addr,
    output logic                   if_stall_req,
    output logic [InstBus-1:0]     inst_out,
    output logic [InstAddrBus-1:0] inst_pc_out,
    output logic                   inst_valid_out
);

    fetch_state_e           r_state,    w_state;
    logic [1:0]             r_cnt,      w_cnt;
    logic [23:0]            r_buf,      w_buf;
    logic [InstAddrBus-1:0] r_pc,       w_pc;
    logic                   r_mem_req,  w_mem_req;
    logic [InstAddrBus-1:0] r_mem_addr, w_mem_addr;
    logic                   r_stall,    w_stall;
    logic [InstBus-1:0]     r_inst,     w_inst;
    logic [InstAddrBus-1:0] r_inst_pc,  w_inst_pc;
    logic                   r_valid,    w_valid;
    logic                   w_fill;
    logic                   w_hit;
    logic [InstBus-1:0]     w_hit_data;

`ifdef ICACHE_EN
    logic w_fill_en;

    assign w_fill_en = w_fill && rdy_in;

    if_fetch_icache #(
        .DEPTH(ICACHE_DEPTH)
    ) u_icache (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .lookup_addr (pc_in),
        .lookup_hit  (w_hit),
        .lookup_data (w_hit_data),
        .fill_en     (w_fill_en),
        .fill_addr   (r_pc),
        .fill_data   (w_inst)
    );
`else
    assign w_hit      = 1'b0;
    assign w_hit_data = ZeroWorld;
`endif

    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_buf      = r_buf;
        w_pc       = r_pc;
        w_mem_req  = r_mem_req;
        w_mem_addr = r_mem_addr;
        w_stall    = r_stall;
        w_inst     = r_inst;
        w_inst_pc  = r_inst_pc;
        w_valid    = r_valid;
        w_fill     = 1'b0;

        // A redirect outranks everything, including a byte completing the word.
        if (branch_or_not) begin
            w_state   = ST_IDLE;
            w_cnt     = 2'd0;
            w_mem_req = 1'b0;
            w_stall   = 1'b0;
            w_valid   = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_valid = 1'b0;
                    if (w_hit) begin
                        w_inst    = w_hit_data;
                        w_inst_pc = pc_in;
                        w_valid   = 1'b1;
                        w_state   = ST_HOLD;
                    end else begin
                        w_pc       = pc_in;
                        w_mem_addr = word_align(pc_in);
                        w_mem_req  = 1'b1;
                        w_stall    = 1'b1;
                        w_cnt      = 2'd0;
                        w_state    = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (mem_byte_valid) begin
                        case (r_cnt)
                            2'd0: w_buf[7:0]   = mem_byte_data;
                            2'd1: w_buf[15:8]  = mem_byte_data;
                            2'd2: w_buf[23:16] = mem_byte_data;
                            default: begin
                                w_inst    = {mem_byte_data, r_buf};
                                w_inst_pc = r_pc;
                                w_valid   = 1'b1;
                                w_mem_req = 1'b0;
                                w_stall   = 1'b0;
                                w_state   = ST_HOLD;
                                w_fill    = 1'b1;
                            end
                        endcase
                        w_cnt = r_cnt + 2'd1;
                    end
                end
                ST_HOLD: begin
                    if (!stall_in[1]) begin
                        w_valid = 1'b0;
                        w_state = ST_IDLE;
                    end
                end
                default: begin
                    w_state   = ST_IDLE;
                    w_cnt     = 2'd0;
                    w_mem_req = 1'b0;
                    w_stall   = 1'b0;
                    w_valid   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 2'd0;
            r_buf      <= '0;
            r_pc       <= ZeroWorld;
            r_mem_req  <= 1'b0;
            r_mem_addr <= ZeroWorld;
            r_stall    <= 1'b0;
            r_inst     <= ZeroWorld;
            r_inst_pc  <= ZeroWorld;
            r_valid    <= 1'b0;
        end else if (rdy_in) begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_buf      <= w_buf;
            r_pc       <= w_pc;
            r_mem_req  <= w_mem_req;
            r_mem_addr <= w_mem_addr;
            r_stall    <= w_stall;
            r_inst     <= w_inst;
            r_inst_pc  <= w_inst_pc;
            r_valid    <= w_valid;
        end
    end

    assign mem_req        = r_mem_req;
    assign mem_addr       = r_mem_addr;
    assign if_stall_req   = r_stall;
    assign inst_out       = r_inst;
    assign inst_pc_out    = r_inst_pc;
    assign inst_valid_out = r_valid;

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: directed fetch sequences push expected words, a monitor checks issues.
module tb_if_fetch;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] pc_in;
    logic        branch_or_not;
    logic [5:0]  stall_in;
    logic        mem_byte_valid;
    logic [7:0]  mem_byte_data;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        if_stall_req;
    logic [31:0] inst_out;
    logic [31:0] inst_pc_out;
    logic        inst_valid_out;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    logic mon_prev = 1'b0;

    if_fetch #(.ICACHE_DEPTH(16)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .pc_in          (pc_in),
        .branch_or_not  (branch_or_not),
        .stall_in       (stall_in),
        .mem_byte_valid (mem_byte_valid),
        .mem_byte_data  (mem_byte_data),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .if_stall_req   (if_stall_req),
        .inst_out       (inst_out),
        .inst_pc_out    (inst_pc_out),
        .inst_valid_out (inst_valid_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push(input logic [31:0] inst, input logic [31:0] pc);
        exp_t e;
        e.inst = inst;
        e.pc   = pc;
        sb_q.push_back(e);
    endtask

    task automatic wait_req(input logic [31:0] addr);
        int n = 0;
        while (!mem_req && n < 20) begin
            tick();
            n++;
        end
        chk("mem_req_seen", {31'd0, mem_req}, 32'd1);
        chk("mem_addr", mem_addr, addr);
        chk("if_stall_req_fetch", {31'd0, if_stall_req}, 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        mem_byte_valid = 1'b1;
        mem_byte_data  = b;
        tick();
        mem_byte_valid = 1'b0;
        mem_byte_data  = 8'h00;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic chk_issue_edge();
        chk("valid_after_last_byte", {31'd0, inst_valid_out}, 32'd1);
        chk("mem_req_dropped", {31'd0, mem_req}, 32'd0);
        chk("if_stall_req_dropped", {31'd0, if_stall_req}, 32'd0);
    endtask

    // Monitor: each rising edge of inst_valid_out is one issued instruction.
    always @(negedge clk_in) begin
        if (inst_valid_out && !mon_prev) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue: got inst 0x%08h pc 0x%08h expected none", inst_out, inst_pc_out);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_inst_out", inst_out, e.inst);
                chk("sb_inst_pc_out", inst_pc_out, e.pc);
            end
        end
        mon_prev = inst_valid_out;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] w;
        logic [31:0] held;

        rst_in = 1'b1; rdy_in = 1'b1; pc_in = 32'h0; branch_or_not = 1'b0;
        stall_in = 6'd0; mem_byte_valid = 1'b0; mem_byte_data = 8'h00;
        repeat (2) tick();
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_if_stall_req", {31'd0, if_stall_req}, 32'd0);
        chk("rst_inst_out", inst_out, 32'h0);
        chk("rst_inst_pc_out", inst_pc_out, 32'h0);
        chk("rst_inst_valid_out", {31'd0, inst_valid_out}, 32'd0);
        rst_in = 1'b0;

        // Back-to-back bytes at pc 0x0
        wait_req(32'h0);
        push(32'h0000_0013, 32'h0);
        send_word(32'h0000_0013);
        chk_issue_edge();
        pc_in = 32'h4;
        tick();
        chk("pulse_one_cycle", {31'd0, inst_valid_out}, 32'd0);

        // Two-cycle gaps between bytes, stall request held throughout
        wait_req(32'h4);
        push(32'h0031_00B3, 32'h4);
        w = 32'h0031_00B3;
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8]);
            if (i < 3) begin
                chk("stall_during_fetch", {31'd0, if_stall_req}, 32'd1);
                repeat (2) begin
                    tick();
                    chk("stall_during_gap", {31'd0, if_stall_req}, 32'd1);
                end
            end
        end
        chk_issue_edge();
        pc_in = 32'h40;
        tick();

        // Redirect after two bytes; a byte arriving with the redirect is dropped
        wait_req(32'h40);
        send_byte(8'hAA);
        send_byte(8'hBB);
        pc_in = 32'h100;
        branch_or_not = 1'b1;
        mem_byte_valid = 1'b1; mem_byte_data = 8'hCC;
        tick();
        branch_or_not = 1'b0;
        mem_byte_valid = 1'b0;
        chk("flush_mem_req", {31'd0, mem_req}, 32'd0);
        chk("flush_valid", {31'd0, inst_valid_out}, 32'd0);
        chk("flush_stall", {31'd0, if_stall_req}, 32'd0);
        wait_req(32'h100);
        push(32'h0000_1237, 32'h100);
        send_word(32'h0000_1237);
        chk_issue_edge();
        pc_in = 32'h80;
        tick();

        // Redirect coincides with the fourth byte: nothing is issued
        wait_req(32'h80);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        pc_in = 32'h140;
        branch_or_not = 1'b1;
        mem_byte_valid = 1'b1; mem_byte_data = 8'h04;
        tick();
        branch_or_not = 1'b0;
        mem_byte_valid = 1'b0;
        chk("flush_4th_valid", {31'd0, inst_valid_out}, 32'd0);
        chk("flush_4th_mem_req", {31'd0, mem_req}, 32'd0);
        wait_req(32'h140);
        push(32'h00A0_0513, 32'h140);
        send_word(32'h00A0_0513);
        chk_issue_edge();
        pc_in = 32'h200;
        tick();

        // ID stalls for three cycles at completion; stray bytes in HOLD ignored
        wait_req(32'h200);
        push(32'h0010_0193, 32'h200);
        send_word(32'h0010_0193);
        pc_in = 32'h300;
        stall_in = 6'b000010;
        mem_byte_valid = 1'b1; mem_byte_data = 8'hFF;
        held = 32'h0010_0193;
        for (int k = 0; k < 4; k++) begin
            chk("hold_valid", {31'd0, inst_valid_out}, 32'd1);
            chk("hold_inst_stable", inst_out, held);
            if (k == 3) begin
                stall_in = 6'd0;
                mem_byte_valid = 1'b0;
            end
            tick();
        end
        chk("hold_released", {31'd0, inst_valid_out}, 32'd0);

        // Global not-ready mid-fetch while bytes pulse
        wait_req(32'h300);
        push(32'hDEAD_BEEF, 32'h300);
        send_byte(8'hEF);
        send_byte(8'hBE);
        rdy_in = 1'b0;
        mem_byte_valid = 1'b1; mem_byte_data = 8'h55;
        tick();
        chk("rdy_low_mem_req_held", {31'd0, mem_req}, 32'd1);
        tick();
        chk("rdy_low_valid_held", {31'd0, inst_valid_out}, 32'd0);
        rdy_in = 1'b1;
        mem_byte_valid = 1'b0;
        send_byte(8'hAD);
        chk("rdy_resume_no_early_issue", {31'd0, inst_valid_out}, 32'd0);
        send_byte(8'hDE);
        chk_issue_edge();
        pc_in = 32'h400;
        tick();

        // Reset mid-fetch, applied while not ready
        wait_req(32'h400);
        send_byte(8'h11);
        send_byte(8'h22);
        rdy_in = 1'b0;
        rst_in = 1'b1;
        tick();
        chk("midrst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("midrst_mem_addr", mem_addr, 32'h0);
        chk("midrst_stall", {31'd0, if_stall_req}, 32'd0);
        chk("midrst_inst_out", inst_out, 32'h0);
        chk("midrst_inst_pc_out", inst_pc_out, 32'h0);
        rst_in = 1'b0;
        rdy_in = 1'b1;
        pc_in = 32'h500;
        wait_req(32'h500);
        push(32'h1122_3344, 32'h500);
        send_word(32'h1122_3344);
        chk_issue_edge();
        pc_in = 32'h8;
        tick();

        // Refetch of the same address: cache hit when enabled, memory otherwise
        wait_req(32'h8);
        push(32'h0050_0093, 32'h8);
        send_word(32'h0050_0093);
        chk_issue_edge();
        tick();
        chk("refetch_idle_valid", {31'd0, inst_valid_out}, 32'd0);
        chk("refetch_idle_mem_req", {31'd0, mem_req}, 32'd0);
`ifdef ICACHE_EN
        push(32'h0050_0093, 32'h8);
        tick();
        chk("hit_valid", {31'd0, inst_valid_out}, 32'd1);
        chk("hit_no_mem_req", {31'd0, mem_req}, 32'd0);
        chk("hit_inst_out", inst_out, 32'h0050_0093);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        tick();
        chk("after_rst_miss_req", {31'd0, mem_req}, 32'd1);
        chk("after_rst_miss_valid", {31'd0, inst_valid_out}, 32'd0);
        chk("after_rst_miss_addr", mem_addr, 32'h8);
`else
        tick();
        chk("nocache_refetch_req", {31'd0, mem_req}, 32'd1);
        chk("nocache_refetch_valid", {31'd0, inst_valid_out}, 32'd0);
        chk("nocache_refetch_addr", mem_addr, 32'h8);
`endif
        push(32'h0050_0093, 32'h8);
        send_word(32'h0050_0093);
        chk_issue_edge();
        pc_in = 32'hC;
        repeat (3) tick();

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have parameter ICACHE_DEPTH, default 16, number of direct-mapped instruction cache lines (power of two; used only with ICACHE_EN).
REQ-002 SHALL have port clk_in  input  1  the single clock, all state updates on its rising edge.
REQ-003 SHALL have port rst_in  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port rdy_in  input  1  global ready; when low, all state and outputs hold.
REQ-005 SHALL have port pc_in  input  32  fetch address from pc.
REQ-006 SHALL have port branch_or_not  input  1  redirect/flush from ex.
REQ-007 SHALL have port stall_in  input  6  stall vector from stall ctrl; bit 1 high = ID cannot accept.
REQ-008 SHALL have port mem_byte_valid  input  1  memory controller returns one instruction byte this cycle.
REQ-009 SHALL have port mem_byte_data  input  8  returned byte.
REQ-010 SHALL have port mem_req  output  1  fetch request to memory controller.
REQ-011 SHALL have port mem_addr  output  32  word-aligned fetch base address.
REQ-012 SHALL have port if_stall_req  output  1  asks stall ctrl to freeze pc while fetching.
REQ-013 SHALL have port inst_out  output  32  fetched instruction to IF/ID.
REQ-014 SHALL have port inst_pc_out  output  32  address of inst_out.
REQ-015 SHALL have port inst_valid_out  output  1  inst_out/inst_pc_out valid.

Function
REQ-016 SHALL implement FSM IDLE, FETCH, HOLD; byte counter 2 bits.
REQ-017 IDLE, rdy_in=1, no branch: SHALL latch pc_in, raise mem_req and if_stall_req next cycle, mem_addr=latched pc, enter FETCH.
REQ-018 FETCH: each mem_byte_valid SHALL store byte at position counter (little-endian: byte0 -> bits 7:0), counter increments.
REQ-019 4th byte SHALL drop mem_req, drop if_stall_req and assert inst_valid_out with assembled word on the next cycle (latency 1 after last byte).
REQ-020 inst_valid_out with stall_in[1]=0 SHALL be a one-cycle pulse; state returns to IDLE.
REQ-021 inst_valid_out with stall_in[1]=1 SHALL enter HOLD; outputs held stable until stall_in[1]=0, then one more valid cycle, then IDLE.
REQ-022 branch_or_not=1 in any state SHALL, next cycle: mem_req=0, inst_valid_out=0, if_stall_req=0, counter=0, state IDLE; bytes arriving that cycle discarded.
REQ-023 branch_or_not and 4th byte in same cycle: flush wins, no instruction issued.
REQ-024 mem_byte_valid outside FETCH SHALL be ignored.
REQ-025 rdy_in=0 SHALL freeze FSM, counter, outputs; mem_byte_valid ignored that cycle.

Reset
REQ-026 rst_in=1 SHALL, at the clock edge, force IDLE, counter 0, mem_req 0, mem_addr 0, if_stall_req 0, inst_out 0, inst_pc_out 0, inst_valid_out 0, irrespective of rdy_in.
REQ-027 Reset mid-FETCH SHALL abandon the fetch; later bytes ignored until a new request.
REQ-028 With ICACHE_EN, reset SHALL clear all cache valid bits; tag/data need not clear.

Configuration
REQ-029 Macro ICACHE_EN SHALL compile in a direct-mapped cache: index pc[log2(ICACHE_DEPTH)+1:2], tag upper bits.
REQ-030 With ICACHE_EN, hit in IDLE SHALL assert inst_valid_out next cycle with no mem_req; miss follows REQ-017; completed miss fills the line same edge as inst_valid_out rises; flushed fetch does not fill.
REQ-031 Without ICACHE_EN, every fetch SHALL go to memory; ICACHE_DEPTH unused; no cache storage.

Structure
REQ-032 Shared define file SHALL hold InstAddrBus, InstBus, ZeroWorld and FSM state encodings.
REQ-033 Cache SHALL be sub-module icache (lookup combinational, fill/clear synchronous), instantiated only under ICACHE_EN.

Verification
REQ-034 Reset, pc_in=0x0, bytes 0x13,0x00,0x00,0x00 on 4 consecutive cycles -> mem_addr=0x0, inst_out=0x00000013, inst_pc_out=0x0, one-cycle valid.
REQ-035 pc_in=0x4, bytes 0xB3,0x00,0x31,0x00 with 2-cycle gaps -> inst_out=0x003100B3; if_stall_req high from request until valid.
REQ-036 branch_or_not after 2 bytes -> mem_req=0 next cycle, no valid; new fetch at pc_in=0x100 completes with correct word.
REQ-037 stall_in[1]=1 for 3 cycles at completion -> inst_out/inst_valid_out stable 4 cycles, then IDLE.
REQ-038 ICACHE_EN: fetch 0x8 (miss, 0x00500093), refetch 0x8 -> valid 1 cycle after IDLE, mem_req never raised; rst_in then refetch -> miss.
REQ-039 rdy_in=0 for 2 cycles mid-FETCH while mem_byte_valid pulses -> those bytes ignored, counter unchanged, resumes on rdy_in=1.
